// File: rtl/flash_arb_pkg.sv
// rtl/flash_arb_pkg.sv - shared encodings and constants for the flash access arbiter
package flash_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic       CMD_READ    = 1'b1;
    localparam logic       CMD_WRITE   = 1'b0;
    localparam logic [7:0] RDATA_ERR   = 8'hFF;
    localparam logic [7:0] RDATA_WRITE = 8'h00;

endpackage

// File: rtl/flash_access_arbiter_if.sv
// rtl/flash_access_arbiter_if.sv - requester and flash-manager signal bundle for the arbiter
interface flash_access_arbiter_if;

    logic       req0;
    logic       req1;
    logic       cmd0;
    logic       cmd1;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic       done0;
    logic       done1;
    logic [7:0] rdata;
    logic       err;
    logic       busy;
    logic       fl_trg;
    logic       cmd_rx;
    logic [7:0] addr_rx;
    logic [7:0] data_rx;
    logic       tx_trig;
    logic [7:0] data_tx;

    modport slave (
        input  req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1, tx_trig, data_tx,
        output done0, done1, rdata, err, busy, fl_trg, cmd_rx, addr_rx, data_rx
    );

    modport master (
        output req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1, tx_trig, data_tx,
        input  done0, done1, rdata, err, busy, fl_trg, cmd_rx, addr_rx, data_rx
    );

endinterface

// File: rtl/flash_arb_timeout.sv
// rtl/flash_arb_timeout.sv - loadable up-counter with clear and terminal-count flag
module flash_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             enable,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    assign tc = (count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Saturates at terminal count so a stalled enable cannot wrap into a false restart.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/flash_access_arbiter.sv
// rtl/flash_access_arbiter.sv - round-robin arbiter and sequencer in front of the flash manager
module flash_access_arbiter
    import flash_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic                  CLK_50MHZ,
    input  logic                  RST,
    flash_access_arbiter_if.slave bus
);

    state_t     state;
    state_t     state_nxt;
    logic       owner;
    logic       rr;
    logic       any_req;
    logic       grant_sel;
    logic       gnt_cmd;
    logic [7:0] gnt_addr;
    logic [7:0] gnt_wdata;
    logic       tc;
    logic       cmd_q;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic [7:0] rdata_q;
    logic       err_q;

    always_comb begin
        any_req   = bus.req0 | bus.req1;
        grant_sel = (bus.req0 & bus.req1) ? rr : bus.req1;
        gnt_cmd   = grant_sel ? bus.cmd1 : bus.cmd0;
        gnt_addr  = grant_sel ? bus.addr1 : bus.addr0;
        gnt_wdata = grant_sel ? bus.wdata1 : bus.wdata0;

        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bus.tx_trig || tc) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (!RST) begin
            state   <= IDLE;
            owner   <= 1'b0;
            rr      <= 1'b0;
            cmd_q   <= CMD_WRITE;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner  <= grant_sel;
                        cmd_q  <= gnt_cmd;
                        addr_q <= gnt_addr;
                        data_q <= gnt_wdata;
                    end
                end
                WAIT: begin
                    // A completion arriving on the timeout cycle still counts as success.
                    if (bus.tx_trig) begin
                        rdata_q <= (cmd_q == CMD_READ) ? bus.data_tx : RDATA_WRITE;
                        err_q   <= 1'b0;
                    end else if (tc) begin
                        rdata_q <= RDATA_ERR;
                        err_q   <= 1'b1;
                    end
                end
                RESP:    rr <= ~owner;
                default: ;
            endcase
        end
    end

    // ISSUE loads 1 so the terminal count lands TIMEOUT_CYCLES cycles after fl_trg.
    flash_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk      (CLK_50MHZ),
        .resetn   (RST),
        .clear    ((state == IDLE) || (state == RESP)),
        .load     (state == ISSUE),
        .load_val (CNT_W'(1)),
        .enable   (state == WAIT),
        .tc       (tc)
    );

    assign bus.fl_trg  = (state == ISSUE);
    assign bus.busy    = (state != IDLE);
    assign bus.done0   = (state == RESP) && !owner;
    assign bus.done1   = (state == RESP) && owner;
    assign bus.cmd_rx  = cmd_q;
    assign bus.addr_rx = addr_q;
    assign bus.data_rx = data_q;
    assign bus.rdata   = rdata_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_flash_access_arbiter.sv
// tb/tb_flash_access_arbiter.sv - scoreboard bench for flash_access_arbiter
module tb_flash_access_arbiter;

    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    flash_access_arbiter_if bus();

    flash_access_arbiter #(
        .TIMEOUT_CYCLES (T),
        .CNT_W          (11)
    ) dut (
        .CLK_50MHZ (clk),
        .RST       (rst),
        .bus       (bus)
    );

    typedef struct {
        int         port;
        logic [7:0] rdata;
        logic       err;
        int         due;
    } resp_t;

    resp_t      sb[$];
    resp_t      mon_e;
    int         done_log[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         m_rr = 0;
    int         mgr_mode = 0;
    int         mgr_delay = 1;
    logic [7:0] mgr_data = 8'h00;
    int         last_tx = -1;
    logic [7:0] last_rdata = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_cmd = 1'b0;
    logic [7:0] exp_addr = 8'h00;
    logic [7:0] exp_wdata = 8'h00;
    logic       s_req[2];
    logic       s_cmd[2];
    logic [7:0] s_addr[2];
    logic [7:0] s_wdata[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        s_req[0] = bus.req0;   s_req[1] = bus.req1;
        s_cmd[0] = bus.cmd0;   s_cmd[1] = bus.cmd1;
        s_addr[0] = bus.addr0; s_addr[1] = bus.addr1;
        s_wdata[0] = bus.wdata0; s_wdata[1] = bus.wdata1;
    end

    // Flash manager model plus arbitration reference: decides the owner from the
    // requests present at the grant edge and predicts the response it will cause.
    initial begin
        bus.tx_trig = 1'b0;
        bus.data_tx = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.fl_trg === 1'b1) begin
                int         t;
                int         own;
                int         d;
                logic [7:0] dv;
                logic       to;
                resp_t      e;
                t = cyc;
                if (last_tx >= 0) chk("trig_gap_ge3", 32'(t - last_tx >= 3), 1);
                if (!s_req[0] && !s_req[1]) begin
                    total++; bad++;
                    $display("FAIL grant_without_req: fl_trg=1 expected no grant (cycle %0d)", cyc);
                end
                own = (s_req[0] && s_req[1]) ? m_rr : (s_req[1] ? 1 : 0);
                chk("cmd_rx", bus.cmd_rx, s_cmd[own]);
                chk("addr_rx", bus.addr_rx, s_addr[own]);
                chk("data_rx", bus.data_rx, s_wdata[own]);
                exp_cmd = s_cmd[own]; exp_addr = s_addr[own]; exp_wdata = s_wdata[own];
                exp_valid = 1'b1;
                dv = 8'($urandom);
                d  = $urandom_range(1, T - 1);
                to = 1'b0;
                if (mgr_mode == 2) to = 1'b1;
                else if (mgr_mode == 1) begin d = mgr_delay; dv = mgr_data; end
                else to = ($urandom_range(0, 5) == 0);
                e.port  = own;
                e.err   = to;
                e.rdata = to ? 8'hFF : (s_cmd[own] ? dv : 8'h00);
                e.due   = to ? t + T : t + d + 1;
                sb.push_back(e);
                m_rr = 1 - own;
                if (!to) begin
                    repeat (d) @(posedge clk);
                    #1;
                    bus.tx_trig = 1'b1;
                    bus.data_tx = dv;
                    last_tx = cyc;
                    @(posedge clk);
                    #1;
                    bus.tx_trig = 1'b0;
                    bus.data_tx = 8'($urandom);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.done0 === 1'b1 || bus.done1 === 1'b1) begin
            chk("done_onehot", 32'(bus.done0 & bus.done1), 0);
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: done0=%b done1=%b expected none (cycle %0d)",
                         bus.done0, bus.done1, cyc);
            end else begin
                mon_e = sb.pop_front();
                done_log.push_back(bus.done1 ? 1 : 0);
                chk("done_port", bus.done1 ? 1 : 0, mon_e.port);
                chk("rdata", bus.rdata, mon_e.rdata);
                chk("err", bus.err, mon_e.err);
                chk("done_cycle", cyc, mon_e.due);
                chk("busy_at_done", bus.busy, 1);
                last_rdata = mon_e.rdata;
                exp_valid = 1'b0;
            end
        end else if (exp_valid && bus.busy === 1'b1 && bus.fl_trg !== 1'b1) begin
            chk("hold_cmd_rx", bus.cmd_rx, exp_cmd);
            chk("hold_addr_rx", bus.addr_rx, exp_addr);
            chk("hold_data_rx", bus.data_rx, exp_wdata);
        end
    end

    task automatic set_port(input int p, input logic r, input logic c, input logic [7:0] a,
                            input logic [7:0] w);
        if (p == 0) begin bus.req0 = r; bus.cmd0 = c; bus.addr0 = a; bus.wdata0 = w; end
        else        begin bus.req1 = r; bus.cmd1 = c; bus.addr1 = a; bus.wdata1 = w; end
    endtask

    task automatic set_req(input int p, input logic r);
        if (p == 0) bus.req0 = r;
        else        bus.req1 = r;
    endtask

    // hold_mode: 0 drop req between transactions, 1 keep it high, 2 random choice.
    task automatic run_port(input int p, input int n, input int hold_mode, input bit fixed,
                            input logic c, input logic [7:0] a, input logic [7:0] w);
        int   budget;
        int   k;
        logic dn;
        @(posedge clk); #1;
        if (fixed) set_port(p, 1'b1, c, a, w);
        else set_port(p, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        for (int i = 0; i < n; i++) begin
            budget = 0;
            do begin
                @(negedge clk);
                budget++;
                dn = (p == 0) ? bus.done0 : bus.done1;
            end while (dn !== 1'b1 && budget < 300);
            if (dn !== 1'b1) begin
                total++; bad++;
                $display("FAIL req_wait_port%0d: done=%b expected 1 within 300 cycles", p, dn);
                set_req(p, 1'b0);
                return;
            end
            if (i == n - 1 || hold_mode == 0 || (hold_mode == 2 && $urandom_range(0, 1) == 0)) begin
                @(posedge clk); #1;
                set_req(p, 1'b0);
                if (i != n - 1) begin
                    k = $urandom_range(0, 3);
                    repeat (k) begin @(posedge clk); #1; end
                    set_port(p, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
                end
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_fl_trg"}, bus.fl_trg, 0);
        chk({tag, "_done0"}, bus.done0, 0);
        chk({tag, "_done1"}, bus.done1, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_rdata"}, bus.rdata, 0);
        chk({tag, "_addr_rx"}, bus.addr_rx, 0);
        chk({tag, "_data_rx"}, bus.data_rx, 0);
        chk({tag, "_cmd_rx"}, bus.cmd_rx, 0);
    endtask

    task automatic idle_trig(input string tag);
        @(posedge clk); #1;
        bus.tx_trig = 1'b1;
        bus.data_tx = 8'h99;
        @(posedge clk); #1;
        bus.tx_trig = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_rdata"}, bus.rdata, last_rdata);
    endtask

    initial begin
        int budget;
        set_port(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_port(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        idle_trig("spurious_idle");

        mgr_mode = 1; mgr_delay = 5; mgr_data = 8'hA5;
        run_port(0, 1, 0, 1'b1, 1'b1, 8'h12, 8'h00);

        mgr_delay = 4; mgr_data = 8'h77;
        run_port(1, 1, 0, 1'b1, 1'b0, 8'h40, 8'h3C);

        mgr_mode = 2;
        run_port(0, 1, 0, 1'b1, 1'b1, 8'h55, 8'h00);
        idle_trig("late_trig");

        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b1, 8'h21, 8'h00);
        budget = 0;
        do begin @(negedge clk); budget++; end while (bus.fl_trg !== 1'b1 && budget < 50);
        chk("mid_wait_fl_trg_seen", bus.fl_trg, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        exp_valid = 1'b0;
        m_rr = 0;
        @(negedge clk);
        check_reset_vals("mid_wait_reset");
        repeat (T + 4) @(negedge clk);

        mgr_mode = 0;
        done_log.delete();
        fork
            run_port(0, 3, 1, 1'b1, 1'b1, 8'h0A, 8'h00);
            run_port(1, 3, 1, 1'b1, 1'b0, 8'h0B, 8'hC3);
        join
        chk("alt_count", done_log.size(), 6);
        for (int i = 0; i < done_log.size() && i < 6; i++)
            chk("alt_order", done_log[i], i % 2);

        mgr_mode = 1; mgr_delay = T - 1; mgr_data = 8'h5A;
        run_port(1, 1, 0, 1'b1, 1'b1, 8'h66, 8'h00);

        mgr_mode = 0;
        fork
            run_port(0, 25, 2, 1'b0, 1'b0, 8'h00, 8'h00);
            run_port(1, 25, 2, 1'b0, 1'b0, 8'h00, 8'h00);
        join

        budget = 0;
        while (sb.size() != 0 && budget < 100) begin @(negedge clk); budget++; end
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
